// File: rtl/audio_pkg.sv
// Shared constants, types and sample conversion for the I2S audio transmitter.
package audio_pkg;

    localparam int SAMPLE_W   = 8;
    localparam int AUDIO_W    = 16;
    localparam int FRAME_BITS = 32;

    typedef enum logic {
        START,
        RUN
    } tx_state_t;

    // Offset-binary 8-bit to signed 16-bit: flip the sign bit, left-justify.
    function automatic logic [AUDIO_W-1:0] u8_to_s16(
        input logic [SAMPLE_W-1:0] s
    );
        return {~s[SAMPLE_W-1], s[SAMPLE_W-2:0], 8'h00};
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO; read data comes straight from the registered head.
module sample_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_d;
    logic             full_q;
    logic             empty_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full_q;
    assign do_pop  = pop && !empty_q;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (do_push) begin
            mem_q[wr_q] <= din;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + AW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + AW'(1);
            end
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == FULL_CNT);
            empty_q <= (cnt_d == '0);
        end
    end

    assign dout  = mem_q[rd_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S transmitter: buffers 8-bit samples and serializes them as 16-bit
// stereo words, generating BCLK and DACLRCK from the system clock.
module audio_i2s_tx
    import audio_pkg::*;
#(
    parameter int BCLK_HALF  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    output logic                sample_ready,
    input  logic                mute,
    output logic                AUD_BCLK,
    output logic                AUD_DACLRCK,
    output logic                AUD_DACDAT,
    output logic                underrun
);

    localparam int          DW      = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(BCLK_HALF - 1);

    tx_state_t             state_q;
    logic [DW-1:0]         div_q;
    logic [DW-1:0]         div_d;
    logic [4:0]            bit_q;
    logic [4:0]            bit_d;
    logic [FRAME_BITS-1:0] frame_q;
    logic                  bclk_q;
    logic                  lrck_q;
    logic                  dat_q;
    logic                  underrun_q;

    logic                  tick;
    logic                  fall;
    logic                  frame_start;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [SAMPLE_W-1:0]   fifo_dout;
    logic [AUDIO_W-1:0]    word;

    assign tick        = (div_q == DIV_MAX);
    assign div_d       = tick ? '0 : div_q + DW'(1);
    assign fall        = tick && bclk_q;
    assign bit_d       = bit_q + 5'd1;
    assign frame_start = fall && ((bit_d == 5'd0) || (state_q == START));
    assign word        = u8_to_s16(fifo_dout);

    sample_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clk   (Clk),
        .Reset (Reset),
        .push  (sample_valid),
        .pop   (frame_start),
        .din   (sample_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= START;
            div_q      <= '0;
            bit_q      <= 5'd31;
            frame_q    <= '0;
            bclk_q     <= 1'b0;
            lrck_q     <= 1'b0;
            dat_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            div_q      <= div_d;
            if (tick) begin
                bclk_q <= ~bclk_q;
            end
            if (fall) begin
                bit_q  <= bit_d;
                lrck_q <= bit_d[4];
                // One-bit I2S delay: output last event's MSB before reloading.
                dat_q  <= frame_q[FRAME_BITS-1];
                if (frame_start) begin
                    state_q <= RUN;
                    if (fifo_empty) begin
                        frame_q    <= '0;
                        underrun_q <= 1'b1;
                    end else if (mute) begin
                        frame_q <= '0;
                    end else begin
                        frame_q <= {word, word};
                    end
                end else begin
                    frame_q <= {frame_q[FRAME_BITS-2:0], 1'b0};
                end
            end
        end
    end

    assign sample_ready = !fifo_full;
    assign AUD_BCLK     = bclk_q;
    assign AUD_DACLRCK  = lrck_q;
    assign AUD_DACDAT   = dat_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Self-checking bench for audio_i2s_tx with BCLK_HALF = 2 (128 Clk frames).
`timescale 1ns/1ps
module tb_audio_i2s_tx;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] sample_in = 8'h00;
    logic       sample_valid = 1'b0;
    logic       mute = 1'b0;
    logic       sample_ready;
    logic       AUD_BCLK;
    logic       AUD_DACLRCK;
    logic       AUD_DACDAT;
    logic       underrun;

    int checks = 0;
    int errors = 0;

    audio_i2s_tx #(
        .BCLK_HALF  (2),
        .FIFO_DEPTH (4)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .mute         (mute),
        .AUD_BCLK     (AUD_BCLK),
        .AUD_DACLRCK  (AUD_DACLRCK),
        .AUD_DACDAT   (AUD_DACDAT),
        .underrun     (underrun)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Model: Clk edges since reset release, sample queue, per-frame content.
    int          m_t = 0;
    logic [7:0]  m_q[$];
    logic [31:0] m_frames[$];
    bit          m_urun[$];

    function automatic logic [15:0] to_s16(input logic [7:0] s);
        int v;
        v = (int'(s) - 128) * 256;
        return v[15:0];
    endfunction

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_t = 0;
            m_q.delete();
            m_frames.delete();
            m_urun.delete();
        end else begin
            int  k;
            bit  can_push;
            logic [7:0]  s;
            logic [15:0] w;
            can_push = sample_valid && (m_q.size() < 4);
            m_t++;
            k = m_t / 4;
            if ((m_t % 4 == 0) && ((k - 1) % 32 == 0)) begin
                if (m_q.size() > 0) begin
                    s = m_q.pop_front();
                    w = to_s16(s);
                    m_frames.push_back(mute ? 32'h0 : {w, w});
                    m_urun.push_back(1'b0);
                end else begin
                    m_frames.push_back(32'h0);
                    m_urun.push_back(1'b1);
                end
            end
            if (can_push) begin
                m_q.push_back(sample_in);
            end
        end
    end

    always @(negedge Clk) begin
        int k;
        int m;
        logic e_bclk, e_lr, e_dat, e_ur, e_rdy;
        k      = m_t / 4;
        e_bclk = ((m_t / 2) % 2) == 1;
        e_lr   = (k == 0) ? 1'b0 : (((k - 1) % 32) >= 16);
        if (k < 2) begin
            e_dat = 1'b0;
        end else begin
            m     = k - 2;
            e_dat = m_frames[m / 32][31 - (m % 32)];
        end
        e_ur  = (m_t > 0 && m_t % 4 == 0 && (k - 1) % 32 == 0) ?
                m_urun[(k - 1) / 32] : 1'b0;
        e_rdy = m_q.size() < 4;
        chk("bclk", 32'(AUD_BCLK), 32'(e_bclk));
        chk("daclrck", 32'(AUD_DACLRCK), 32'(e_lr));
        chk("dacdat", 32'(AUD_DACDAT), 32'(e_dat));
        chk("underrun", 32'(underrun), 32'(e_ur));
        chk("sample_ready", 32'(sample_ready), 32'(e_rdy));
    end

    int ur_seen = 0;
    always @(negedge Clk) begin
        if (!Reset && underrun) begin
            ur_seen++;
        end
    end

    task automatic wait_t(input int n);
        while (m_t < n) @(negedge Clk);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        #2;
        Reset        = 1'b1;
        sample_valid = 1'b0;
        mute         = 1'b0;
        repeat (3) @(negedge Clk);
        #2;
        Reset = 1'b0;
    endtask

    task automatic get_frame(input int f, output logic [31:0] w);
        w = '0;
        for (int j = 0; j < 32; j++) begin
            wait_t(128 * f + 8 + 4 * j);
            w = {w[30:0], AUD_DACDAT};
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] fw;
        int          base;
        logic        r;

        // Idle: underrun every frame, data stays zero.
        do_reset();
        base = ur_seen;
        wait_t(300);
        chk("idle_underrun_count", 32'(ur_seen - base), 32'd3);

        // Single sample 0xFF before first frame start.
        do_reset();
        base         = ur_seen;
        sample_in    = 8'hFF;
        sample_valid = 1'b1;
        wait_t(1);
        sample_valid = 1'b0;
        get_frame(0, fw);
        chk("single_frame", fw, 32'h7F007F00);
        chk("single_no_underrun", 32'(ur_seen - base), 32'd0);

        // Fill and backpressure with 0x10, 0x20, ...
        do_reset();
        sample_in    = 8'h10;
        sample_valid = 1'b1;
        fork
            begin
                while (m_t < 650) begin
                    r = sample_ready;
                    @(negedge Clk);
                    if (r) sample_in = sample_in + 8'h10;
                end
                sample_valid = 1'b0;
            end
            begin
                wait_t(5);
                chk("fill_ready_low", 32'(sample_ready), 32'd0);
                get_frame(0, fw);
                chk("fill_frame0", fw, 32'h90009000);
                chk("fill_ready_rise", 32'(sample_ready), 32'd1);
                wait_t(133);
                chk("fill_ready_refull", 32'(sample_ready), 32'd0);
                get_frame(1, fw);
                chk("fill_frame1", fw, 32'hA000A000);
                get_frame(2, fw);
                chk("fill_frame2", fw, 32'hB000B000);
                get_frame(3, fw);
                chk("fill_frame3", fw, 32'hC000C000);
                get_frame(4, fw);
                chk("fill_frame4", fw, 32'hD000D000);
            end
        join

        // Mute during first frame start only.
        do_reset();
        sample_in    = 8'h00;
        sample_valid = 1'b1;
        wait_t(1);
        sample_in    = 8'hC0;
        wait_t(2);
        sample_valid = 1'b0;
        wait_t(3);
        mute = 1'b1;
        wait_t(4);
        mute = 1'b0;
        get_frame(0, fw);
        chk("mute_frame0", fw, 32'h00000000);
        get_frame(1, fw);
        chk("mute_frame1", fw, 32'h40004000);
        wait_t(260);
        chk("mute_drained_underrun", 32'(underrun), 32'd1);
        chk("mute_drained_ready", 32'(sample_ready), 32'd1);

        // Push coincident with frame start on an empty FIFO.
        do_reset();
        wait_t(3);
        sample_in    = 8'h33;
        sample_valid = 1'b1;
        wait_t(4);
        sample_valid = 1'b0;
        chk("coinc_underrun", 32'(underrun), 32'd1);
        get_frame(0, fw);
        chk("coinc_frame0", fw, 32'h00000000);
        get_frame(1, fw);
        chk("coinc_frame1", fw, 32'hB300B300);

        // Reset mid-frame with three samples queued.
        do_reset();
        sample_in    = 8'h11;
        sample_valid = 1'b1;
        wait_t(1);
        sample_in    = 8'h22;
        wait_t(2);
        sample_in    = 8'h33;
        wait_t(3);
        sample_in    = 8'h44;
        wait_t(4);
        sample_valid = 1'b0;
        wait_t(44);
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        #1;
        chk("rst_bclk", 32'(AUD_BCLK), 32'd0);
        chk("rst_lrck", 32'(AUD_DACLRCK), 32'd0);
        chk("rst_dat", 32'(AUD_DACDAT), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_ready", 32'(sample_ready), 32'd1);
        repeat (2) @(negedge Clk);
        #2;
        Reset = 1'b0;
        wait_t(4);
        chk("rst_first_underrun", 32'(underrun), 32'd1);
        get_frame(0, fw);
        chk("rst_frame0", fw, 32'h00000000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
